// File: rtl/bcd_op_sequencer.sv
// bcd_op_sequencer
//   Multi-cycle arithmetic controller for the calculator. One start pulse, sampled
//   while idle, computes add/sub/mul/div of two packed-BCD operands. All digit work
//   goes through a single shared BCD digit adder/subtractor, one digit per clock.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, op          request pulse and operation (00 add, 01 sub, 10 mul, 11 div)
//   num1_bcd/num2_bcd  operands A/B, packed BCD, MSD in the top nibble
//   result_bcd         result magnitude; held until a new result is written
//   neg/ovf/err        sign (sub), overflow, divide-by-zero / illegal BCD
//   busy/done          handshake: busy from the cycle after start up to and
//                      including the one-cycle done pulse
//
// Build option
//   OPSEQ_BCD_CHECK_EN : when defined, operand nibbles > 9 abort in LOAD with
//                        err=1 and result 0 (same exit as divide by zero).
module bcd_op_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [4*DIGITS-1:0]   num1_bcd,
  input  logic [4*DIGITS-1:0]   num2_bcd,
  output logic [4*DIGITS-1:0]   result_bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4*DIGITS;
  localparam int W1 = W + 4;                  // one guard digit for the division remainder
  localparam int IW = $clog2(DIGITS+1) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, DSTEP, SHIFT, CMP, FINISH} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q, b_q, quo_q;
  logic [W1-1:0]   acc_q, addend_q;
  logic [IW-1:0]   di_q, bi_q, last_di;
  logic [3:0]      rep_q;
  logic            sub_q, cy_q, neg_q, ovf_q, err_q;

  // ---------------- shared BCD digit adder/subtractor ----------------
  logic [3:0] x_dig, y_raw, y_dig, s_dig;
  logic [4:0] sum5, adj;
  logic       cout;

  always_comb begin
    x_dig = acc_q[di_q*4 +: 4];
    y_raw = addend_q[di_q*4 +: 4];
    y_dig = sub_q ? (4'd9 - y_raw) : y_raw;   // nine's complement for subtraction
    sum5  = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0, cy_q};
    adj   = sum5 - 5'd10;
    cout  = (sum5 > 5'd9);
    s_dig = cout ? adj[3:0] : sum5[3:0];
  end

  // Division passes run over the guard digit too; other passes cover DIGITS digits.
  assign last_di = (op_q == OP_DIV) ? IW'(DIGITS) : IW'(DIGITS-1);

  logic pass_end, b_zero, a_lt_b, rem_ge, cmp_go, bad_bcd, accept;

  assign pass_end = (di_q == last_di);
  assign b_zero   = (b_q == '0);
  assign a_lt_b   = (a_q < b_q);               // packed BCD orders like unsigned binary
  assign rem_ge   = (acc_q >= {4'b0, b_q});
  assign cmp_go   = (op_q == OP_MUL) ? (rep_q != 4'd0) : rem_ge;
  assign accept   = (state_q == IDLE) && start && !busy;

`ifdef OPSEQ_BCD_CHECK_EN
  function automatic logic has_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (v[k*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction
  assign bad_bcd = has_bad(a_q) || has_bad(b_q);
`else
  assign bad_bcd = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = LOAD;
      LOAD: begin
        if (bad_bcd || (op_q == OP_DIV && b_zero)) state_d = FINISH;
        else if (op_q == OP_ADD || op_q == OP_SUB)  state_d = DSTEP;
        else                                        state_d = SHIFT;
      end
      DSTEP:  if (pass_end) state_d = (op_q == OP_ADD || op_q == OP_SUB) ? FINISH : CMP;
      SHIFT:  state_d = CMP;
      CMP: begin
        if (cmp_go)              state_d = DSTEP;
        else if (bi_q == '0)     state_d = FINISH;
        else                     state_d = SHIFT;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath and outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; a_q <= '0; b_q <= '0; quo_q <= '0;
      acc_q <= '0; addend_q <= '0; di_q <= '0; bi_q <= '0; rep_q <= '0;
      sub_q <= 1'b0; cy_q <= 1'b0; neg_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0;
      result_bcd <= '0; neg <= 1'b0; ovf <= 1'b0; err <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;

      case (state_q)
        IDLE: if (accept) begin
          op_q  <= op;
          a_q   <= num1_bcd;
          b_q   <= num2_bcd;
          neg_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0;
          neg   <= 1'b0; ovf   <= 1'b0; err   <= 1'b0;
          busy  <= 1'b1;
        end

        LOAD: begin
          bi_q  <= IW'(DIGITS-1);
          di_q  <= '0;
          quo_q <= '0;
          rep_q <= '0;
          if (bad_bcd) err_q <= 1'b1;
          case (op_q)
            OP_ADD: begin
              acc_q <= {4'b0, a_q}; addend_q <= {4'b0, b_q};
              sub_q <= 1'b0; cy_q <= 1'b0;
            end
            OP_SUB: begin
              // Always subtract the smaller magnitude; sign comes from the swap.
              if (a_lt_b) begin
                acc_q <= {4'b0, b_q}; addend_q <= {4'b0, a_q}; neg_q <= 1'b1;
              end else begin
                acc_q <= {4'b0, a_q}; addend_q <= {4'b0, b_q};
              end
              sub_q <= 1'b1; cy_q <= 1'b1;
            end
            OP_MUL: begin
              acc_q <= '0; addend_q <= {4'b0, a_q}; sub_q <= 1'b0;
            end
            default: begin
              if (b_zero) err_q <= 1'b1;
              acc_q <= '0; addend_q <= {4'b0, b_q}; sub_q <= 1'b1;
            end
          endcase
        end

        DSTEP: begin
          acc_q[di_q*4 +: 4] <= s_dig;
          cy_q <= cout;
          if (pass_end) begin
            di_q <= '0;
            // For sub passes the final carry only means "no borrow".
            if (cout && (op_q == OP_ADD || op_q == OP_MUL)) ovf_q <= 1'b1;
            if (op_q == OP_MUL) rep_q <= rep_q - 4'd1;
            if (op_q == OP_DIV) quo_q[3:0] <= quo_q[3:0] + 4'd1;
          end else begin
            di_q <= di_q + IW'(1);
          end
        end

        SHIFT: begin
          if (op_q == OP_MUL) begin
            if (acc_q[W-1 -: 4] != 4'd0) ovf_q <= 1'b1;
            acc_q <= {4'b0, acc_q[W-5:0], 4'b0};
            rep_q <= b_q[bi_q*4 +: 4];
          end else begin
            acc_q <= {acc_q[W1-5:0], a_q[bi_q*4 +: 4]};
            quo_q <= {quo_q[W-5:0], 4'b0};
          end
        end

        CMP: begin
          cy_q <= sub_q;                       // carry-in for the next pass
          di_q <= '0;
          if (!cmp_go && bi_q != '0) bi_q <= bi_q - IW'(1);
        end

        FINISH: begin
          if (err_q)                result_bcd <= '0;
          else if (op_q == OP_DIV)  result_bcd <= quo_q;
          else                      result_bcd <= acc_q[W-1:0];
          neg  <= neg_q && !err_q;
          ovf  <= ovf_q && !err_q;
          err  <= err_q;
          done <= 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_op_sequencer.sv
module tb_bcd_op_sequencer;
  localparam int DIGITS = 4;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [15:0] num1_bcd, num2_bcd, result_bcd;
  logic        neg, ovf, err, busy, done;

  bcd_op_sequencer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .num1_bcd(num1_bcd), .num2_bcd(num2_bcd),
    .result_bcd(result_bcd), .neg(neg), .ovf(ovf), .err(err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, res;
    logic        neg, ovf, err;
    int          lat;          // 0 = latency not checked
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        neg, ovf, err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'h0, result_bcd}, {16'h0, e.res});
        chk("neg", {31'h0, neg}, {31'h0, e.neg});
        chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("err", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  task automatic wait_done(input string tag, output int lat, output logic ok);
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    ok = done;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, lat);
      sb.delete();
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    logic ok;
    e.res = v.res; e.neg = v.neg; e.ovf = v.ovf; e.err = v.err;
    sb.push_back(e);
    @(negedge clk);
    op = v.op; num1_bcd = v.a; num2_bcd = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Inputs wander after start; they must not affect the running op.
    op = 2'($urandom); num1_bcd = 16'($urandom); num2_bcd = 16'($urandom);
    chk({tag, "_busy_after_start"}, {31'h0, busy}, 32'd1);
    wait_done(tag, lat, ok);
    if (ok) begin
      if (v.lat != 0) chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_busy_in_done"}, {31'h0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, "_busy_after_done"}, {31'h0, busy}, 32'd0);
      chk({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    end
  endtask

  initial begin
    int   lat, dcnt;
    logic ok;
    exp_t e;
    vec_t v;

    rst = 1'b1; start = 1'b0; op = ADD; num1_bcd = '0; num2_bcd = '0;

    vt.push_back('{ADD, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 6});
    vt.push_back('{ADD, 16'h9999, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 6});
    vt.push_back('{ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 6});
    vt.push_back('{SUB, 16'h0012, 16'h0345, 16'h0333, 1'b1, 1'b0, 1'b0, 6});
    vt.push_back('{SUB, 16'h0345, 16'h0012, 16'h0333, 1'b0, 1'b0, 1'b0, 6});
    vt.push_back('{SUB, 16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 1'b0, 6});
    vt.push_back('{MUL, 16'h0123, 16'h0045, 16'h5535, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{MUL, 16'h9999, 16'h0002, 16'h9998, 1'b0, 1'b1, 1'b0, 0});
    vt.push_back('{MUL, 16'h0000, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{MUL, 16'h0099, 16'h0099, 16'h9801, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{DIV, 16'h9876, 16'h0012, 16'h0823, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{DIV, 16'h0005, 16'h0009, 16'h0000, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{DIV, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
    vt.push_back('{DIV, 16'h9999, 16'h0001, 16'h9999, 1'b0, 1'b0, 1'b0, 0});

    repeat (3) @(negedge clk);
    chk("reset_result", {16'h0, result_bcd}, 32'h0);
    chk("reset_flags", {29'h0, neg, ovf, err}, 32'h0);
    chk("reset_busy_done", {30'h0, busy, done}, 32'h0);
    rst = 1'b0;

    foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

    // A second start while busy, with a different op and operands, is dropped.
    e.res = 16'h6912; e.neg = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk); op = ADD; num1_bcd = 16'h1234; num2_bcd = 16'h5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); op = SUB; num1_bcd = 16'h0001; num2_bcd = 16'h0002; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("busy_start", lat, ok);
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("busy_start_no_second_done", dcnt, 0);

    // Reset in the middle of a multiply aborts it without a done pulse.
    @(negedge clk); op = MUL; num1_bcd = 16'h9999; num2_bcd = 16'h0002; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_mul_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_result", {16'h0, result_bcd}, 32'h0);
    chk("abort_flags", {29'h0, neg, ovf, err}, 32'h0);
    chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
    rst = 1'b0;
    dcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    v = '{MUL, 16'h0123, 16'h0045, 16'h5535, 1'b0, 1'b0, 1'b0, 0};
    run_op(v, "after_abort");

`ifdef OPSEQ_BCD_CHECK_EN
    v = '{ADD, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
    run_op(v, "bad_bcd");
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
